// File: rtl/fact_accel_if.sv
// -----------------------------------------------------------------------------
// fact_accel_if
// Data-memory bus seen by the factorial accelerator.
//   sel : block select from the system address decoder
//   a   : word offset within the 16-byte window (byte address bits [3:2])
//   we  : write enable (qualified by sel inside the slave)
//   wd  : write data
//   rd  : read data, driven combinationally by the slave
// Modports: master drives sel/a/we/wd and samples rd; slave is the reverse.
// -----------------------------------------------------------------------------
interface fact_accel_if #(
  parameter int WIDTH = 32
);
  logic             sel;
  logic [1:0]       a;
  logic             we;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rd;

  modport master (output sel, output a, output we, output wd, input rd);
  modport slave  (input sel, input a, input we, input wd, output rd);
endinterface

// File: rtl/fact_accel_slave.sv
// -----------------------------------------------------------------------------
// fact_accel_slave
// Memory-mapped iterative factorial accelerator (one multiply per cycle).
// Ports:
//   clk : system clock, rising-edge active
//   rst : asynchronous active-low reset
//   bus : fact_accel_if slave modport (sel, a, we, wd in; rd out)
// Register map (word offset):
//   0 N      : R/W, low N_WIDTH bits stored, read back zero-extended
//   1 GO     : W, wd[0]=1 starts a computation while idle; reads 0
//   2 STATUS : R, {busy, err, done} in bits [2:0]
//   3 RESULT : R, last factorial (0 after an out-of-range request)
// Reads are combinational; rd is 0 whenever sel is low.
// -----------------------------------------------------------------------------
module fact_accel_slave #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4,
  parameter int N_MAX   = 12
) (
  input  logic          clk,
  input  logic          rst,
  fact_accel_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [N_WIDTH-1:0] N_MAX_C = N_WIDTH'(N_MAX);
  localparam logic [N_WIDTH-1:0] CNT_ONE = N_WIDTH'(1);

  localparam logic [1:0] OFF_N      = 2'd0;
  localparam logic [1:0] OFF_GO     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  logic [0:0]         state_q,   state_d;
  logic [N_WIDTH-1:0] n_q,       n_d;
  logic [N_WIDTH-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;
  logic               busy_q,    busy_d;

  logic               wr_en_s;
  logic               go_s;
  logic [WIDTH-1:0]   rd_s;

  assign wr_en_s = bus.we & bus.sel;
  assign go_s    = wr_en_s & (bus.a == OFF_GO) & bus.wd[0];

  // Next-state logic: N register writes, GO acceptance and the multiply loop.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    result_d  = result_q;
    done_d    = done_q;
    err_d     = err_q;
    busy_d    = busy_q;

    // N is writable in any state; a running job keeps its own copy in cnt.
    if (wr_en_s && (bus.a == OFF_N)) begin
      n_d = bus.wd[N_WIDTH-1:0];
    end else begin
      n_d = n_q;
    end

    case (state_q)
      IDLE: begin
        if (go_s) begin
          if (n_q <= N_MAX_C) begin
            state_d   = BUSY;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            cnt_d     = n_q;
            product_d = {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            // Out-of-range N: report immediately without entering BUSY.
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = {WIDTH{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // cnt<=1 covers N=0 and N=1, whose product stays at 1.
        if (cnt_q <= CNT_ONE) begin
          result_d = product_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          product_d = product_q * {{(WIDTH-N_WIDTH){1'b0}}, cnt_q};
          cnt_d     = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= {N_WIDTH{1'b0}};
      cnt_q     <= {N_WIDTH{1'b0}};
      product_q <= {WIDTH{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Combinational read mux so the single-cycle core sees data in the same cycle.
  always_comb begin
    rd_s = {WIDTH{1'b0}};
    if (bus.sel) begin
      case (bus.a)
        OFF_N:      rd_s = {{(WIDTH-N_WIDTH){1'b0}}, n_q};
        OFF_GO:     rd_s = {WIDTH{1'b0}};
        OFF_STATUS: rd_s = {{(WIDTH-3){1'b0}}, busy_q, err_q, done_q};
        OFF_RESULT: rd_s = result_q;
        default:    rd_s = {WIDTH{1'b0}};
      endcase
    end else begin
      rd_s = {WIDTH{1'b0}};
    end
  end

  assign bus.rd = rd_s;

endmodule
